q_edge_monitor: RTL and testbench
=================================

// Module: q_edge_monitor
// PURPOSE
//   Downstream consumer of the enabled D flip-flop output q. Samples q on
//   enabled cycles, emits one-cycle rise/fall pulses, counts rising edges
//   and measures the length of the last completed high pulse in sampled
//   cycles. Gives the bench and later stages a registered event/statistics view of q.
// PARAMETERS
//   CNT_W  8  width of rising-edge counter rise_count
//   LEN_W  8  width of high-pulse length counter / high_len
// PORTS
//   clk         in   1      clock; all state updates on posedge
//   reset       in   1      asynchronous, active-low reset
//   q_in        in   1      q from the upstream D flip-flop
//   en          in   1      sample enable; q_in ignored when 0
//   clr         in   1      synchronous clear of statistics and FSM
//   rise_pulse  out  1      1 for one cycle after a sampled 0->1 edge
//   fall_pulse  out  1      1 for one cycle after a sampled 1->0 edge
//   rise_count  out  CNT_W  number of rising edges since reset/clr (wraps)
//   overflow    out  1      sticky: rise_count wrapped from max to 0
//   high_len    out  LEN_W  length (sampled cycles) of last completed high pulse
//   len_valid   out  1      sticky: high_len holds at least one measurement
// BEHAVIOUR
//   - reset low (async, any time): state=INIT, run_len=0; every output 0.
//     Deassertion is sampled normally; first update on next posedge.
//   - All outputs registered: sample taken at posedge k appears after edge k
//     (latency 1 clock from the sampling edge). No combinational in->out path.
//   - FSM states INIT, LOW, HIGH. Only posedges with en=1 and clr=0 advance it.
//   - INIT: first enabled sample sets baseline, no edge reported.
//       q_in=0 -> LOW;  q_in=1 -> HIGH, run_len=1.
//   - LOW, q_in=0: stay. LOW, q_in=1: rise_pulse=1, rise_count+=1,
//       run_len=1, -> HIGH.
//   - HIGH, q_in=1: stay, run_len+=1, saturating at 2^LEN_W-1.
//   - HIGH, q_in=0: fall_pulse=1, high_len<=run_len, len_valid<=1, -> LOW.
//   - rise_count at 2^CNT_W-1 plus a rise -> 0, overflow<=1 (sticky).
//   - en=0: state, run_len, counters, high_len hold; both pulses 0.
//     A q_in change while en=0 is not an edge; edge judged vs last sampled value.
//   - Pulses last exactly one cycle, then return to 0 on next posedge; never
//     both high together; back-to-back edges give pulses on consecutive cycles.
//   - clr=1 (sync, beats en): rise_count, overflow, high_len, len_valid,
//     run_len <= 0; pulses 0; state <= INIT. No edge from sample that cycle.
//   - reset mid-pulse: in-progress run_len discarded, high_len not updated.
// TESTING (CNT_W=4, LEN_W=4 unless noted)
//   1 reset=0 then 1, en=1, q_in=0,1,1,1,0 on successive edges -> one
//     rise_pulse after 2nd edge, fall_pulse after 5th; rise_count=1,
//     high_len=3, len_valid=1; all outputs 0 while reset=0.
//   2 q_in=1 on first enabled sample after reset -> no rise_pulse,
//     rise_count=0, state HIGH; later 1->0 gives fall_pulse, high_len=1.
//   3 en=0 while q_in toggles 0->1->0, then en=1 with q_in=0 -> no pulses,
//     all counters unchanged.
//   4 17 rising edges -> rise_count=1, overflow=1 after 16th rise; clr=1 one
//     cycle -> rise_count=0, overflow=0, len_valid=0, high_len=0.
//   5 q_in held 1 for 20 enabled cycles then 0 -> high_len=15 (saturated).
//   6 reset asserted asynchronously mid high pulse (between edges) -> outputs
//     0 immediately; after release, q_in=1 gives no rise_pulse (INIT baseline).

Source files
------------

// File: rtl/q_edge_monitor_if.sv
// Bus bundle for q_edge_monitor: sample inputs and registered event view.
// Ports: q_in/en/clr (to monitor), rise/fall pulses, count, overflow, len.
interface q_edge_monitor_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
);
  logic             q_in;
  logic             en;
  logic             clr;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] rise_count;
  logic             overflow;
  logic [LEN_W-1:0] high_len;
  logic             len_valid;

  modport master (
    output q_in, en, clr,
    input  rise_pulse, fall_pulse, rise_count,
    input  overflow, high_len, len_valid
  );

  modport slave (
    input  q_in, en, clr,
    output rise_pulse, fall_pulse, rise_count,
    output overflow, high_len, len_valid
  );
endinterface

// File: rtl/q_edge_monitor.sv
// Registered edge/statistics monitor for a sampled q signal.
// Ports: clk, reset (async active-low), bus (slave: q_in/en/clr in, stats out).
module q_edge_monitor #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
) (
  input logic              clk,
  input logic              reset,
  q_edge_monitor_if.slave  bus
);
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (bus.clr) begin
      state_d = S_INIT;
      run_d   = '0;
      cnt_d   = '0;
      len_d   = '0;
      ovf_d   = 1'b0;
      vld_d   = 1'b0;
    end else if (bus.en) begin
      unique case (state_q)
        S_LOW: begin
          if (bus.q_in) begin
            rise_d  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            ovf_d   = ovf_q | (&cnt_q);
            run_d   = {{(LEN_W-1){1'b0}}, 1'b1};
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (bus.q_in) begin
            // saturate so a very long pulse reads as max
            if (!(&run_q)) run_d = run_q + 1'b1;
          end else begin
            fall_d  = 1'b1;
            len_d   = run_q;
            vld_d   = 1'b1;
            state_d = S_LOW;
          end
        end
        default: begin
          // first sample only sets the baseline
          if (bus.q_in) begin
            run_d   = {{(LEN_W-1){1'b0}}, 1'b1};
            state_d = S_HIGH;
          end else begin
            state_d = S_LOW;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      run_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.rise_count = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.high_len   = len_q;
  assign bus.len_valid  = vld_q;
endmodule

// File: tb/tb_q_edge_monitor.sv
// Scoreboard bench for q_edge_monitor with CNT_W=LEN_W=4.
// Directed scenarios followed by randomized q/en/clr traffic.
module tb_q_edge_monitor;
  localparam int CW = 4;
  localparam int LW = 4;

  typedef struct packed {
    logic          r;
    logic          f;
    logic [CW-1:0] c;
    logic          o;
    logic [LW-1:0] h;
    logic          v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  q_edge_monitor_if #(.CNT_W(CW), .LEN_W(LW)) bus ();

  q_edge_monitor #(.CNT_W(CW), .LEN_W(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // reference: last sampled value plus plain integer statistics
  bit m_base;
  bit m_last;
  int m_rises;
  bit m_ovf;
  int m_run;
  int m_len;
  bit m_vld;

  function automatic exp_t cur_out();
    exp_t e;
    e.r = 1'b0;
    e.f = 1'b0;
    e.c = CW'(m_rises);
    e.o = m_ovf;
    e.h = LW'(m_len);
    e.v = m_vld;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    bit rs;
    bit fl;
    rs = 0;
    fl = 0;
    if (!reset || bus.clr) begin
      m_base = 0; m_last = 0; m_rises = 0;
      m_ovf = 0; m_run = 0; m_len = 0; m_vld = 0;
    end else if (bus.en) begin
      if (m_base && !m_last && bus.q_in) begin
        rs = 1;
        m_rises = (m_rises + 1) % (1 << CW);
        if (m_rises == 0) m_ovf = 1;
      end
      if (m_base && m_last && !bus.q_in) begin
        fl = 1;
        m_len = m_run;
        m_vld = 1;
      end
      if (bus.q_in) begin
        if (!m_base || !m_last) m_run = 1;
        else if (m_run < (1 << LW) - 1) m_run++;
      end
      m_base = 1;
      m_last = bus.q_in;
    end
    e = cur_out();
    e.r = rs;
    e.f = fl;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {bus.rise_pulse, bus.fall_pulse, bus.rise_count,
           bus.overflow, bus.high_len, bus.len_valid};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb t=%0t got r%b f%b c%0d o%b h%0d v%b want r%b f%b c%0d o%b h%0d v%b",
                 $time, a.r, a.f, a.c, a.o, a.h, a.v,
                 e.r, e.f, e.c, e.o, e.h, e.v);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(bit q, bit e, bit c);
    @(negedge clk);
    #1;
    bus.q_in = q;
    bus.en   = e;
    bus.clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string name);
    chk({name, "_outs"},
        int'({bus.rise_pulse, bus.fall_pulse, bus.rise_count,
              bus.overflow, bus.high_len, bus.len_valid}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.q_in = 1'b0;
    bus.en   = 1'b0;
    bus.clr  = 1'b0;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    #1;
    reset = 1'b1;

    // 1: basic pulse of length 3
    step(0, 1, 0);
    step(1, 1, 0);
    chk("t1_rise", int'(bus.rise_pulse), 1);
    step(1, 1, 0);
    chk("t1_rise_off", int'(bus.rise_pulse), 0);
    step(1, 1, 0);
    step(0, 1, 0);
    chk("t1_fall", int'(bus.fall_pulse), 1);
    chk("t1_cnt", int'(bus.rise_count), 1);
    chk("t1_len", int'(bus.high_len), 3);
    chk("t1_vld", int'(bus.len_valid), 1);

    // 2: high baseline gives no rise
    step(0, 1, 1);
    step(1, 1, 0);
    chk("t2_norise", int'(bus.rise_pulse), 0);
    chk("t2_cnt", int'(bus.rise_count), 0);
    step(0, 1, 0);
    chk("t2_fall", int'(bus.fall_pulse), 1);
    chk("t2_len", int'(bus.high_len), 1);

    // 3: toggles while disabled are ignored
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("t3_pulses", int'({bus.rise_pulse, bus.fall_pulse}), 0);
    chk("t3_cnt", int'(bus.rise_count), 0);
    chk("t3_len", int'(bus.high_len), 1);

    // 4: counter wrap and clear
    step(0, 1, 1);
    step(0, 1, 0);
    for (int i = 0; i < 17; i++) begin
      step(1, 1, 0);
      step(0, 1, 0);
      if (i == 15) chk("t4_ovf16", int'(bus.overflow), 1);
    end
    chk("t4_cnt", int'(bus.rise_count), 1);
    chk("t4_ovf", int'(bus.overflow), 1);
    step(1, 1, 1);
    chk_zero("t4_clr");

    // 5: saturating length
    step(0, 1, 0);
    repeat (20) step(1, 1, 0);
    step(0, 1, 0);
    chk("t5_len", int'(bus.high_len), 15);

    // 6: async reset mid pulse
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("t6_async");
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    bus.q_in = 1'b1;
    bus.en   = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_norise", int'(bus.rise_pulse), 0);
    step(0, 1, 0);
    chk("t6_len", int'(bus.high_len), 1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 8,
           $urandom_range(0, 99) < 3);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
